multi_dataflow_mmult_opt_mdc_ctrl_fsm: RTL

MULTI_DATAFLOW_MMULT_OPT_MDC_CTRL_FSM -- requirements
Module: multi_dataflow_mmult_opt_mdc_ctrl_fsm

---
 rtl/multi_dataflow_mmult_opt_mdc_package.sv | 15 +
 rtl/multi_dataflow_mmult_opt_mdc_ctrl_fsm.sv | 124 ++++++++++++
 2 files changed

// File: rtl/multi_dataflow_mmult_opt_mdc_package.sv
// Shared types and sizing for the mmult_opt MDC control FSM.
package multi_dataflow_mmult_opt_mdc_package;

  localparam int unsigned MULTI_DATAFLOW_MMULT_OPT_MDC_CNT_LEN = 32;
  localparam int unsigned MDC_LEN_W = MULTI_DATAFLOW_MMULT_OPT_MDC_CNT_LEN;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_COMPUTE   = 3'd2,
    ST_WAIT_SINK = 3'd3,
    ST_FINISHED  = 3'd4
  } mdc_state_t;

endpackage

// File: rtl/multi_dataflow_mmult_opt_mdc_ctrl_fsm.sv
// Job sequencer for the mmult_opt engine: launches engine and streamers,
// counts out_r beats, waits for the sink to commit, then reports completion.
module multi_dataflow_mmult_opt_mdc_ctrl_fsm
  import multi_dataflow_mmult_opt_mdc_package::*;
#(
  parameter int unsigned LEN_W = MDC_LEN_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             test_mode_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             eng_ready_i,
  input  logic             eng_done_i,
  input  logic             out_valid_i,
  input  logic             out_ready_i,
  input  logic             sink_done_i,
  output logic             eng_start_o,
  output logic             eng_clear_o,
  output logic [1:0]       src_start_o,
  output logic             sink_start_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [LEN_W-1:0] cnt_o,
  output logic             err_o
);

  mdc_state_t       r_state;
  mdc_state_t       w_state_nxt;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic             r_pending;
  logic             r_err;
  logic             r_sink_seen;
  logic             r_clear;
  logic             w_accept;
  logic             w_active;
  logic             w_hs;
  logic             w_unused;

  // Neither input influences sequencing; engine status is not reported here.
  assign w_unused = test_mode_i ^ eng_done_i;

  assign w_active = (r_state == ST_START) || (r_state == ST_COMPUTE) ||
                    (r_state == ST_WAIT_SINK);
  assign w_hs     = out_valid_i & out_ready_i & w_active;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if ((start_i || r_pending) && eng_ready_i) begin
          w_accept    = 1'b1;
          w_state_nxt = (len_i == '0) ? ST_FINISHED : ST_START;
        end
      end
      ST_START:     w_state_nxt = ST_COMPUTE;
      ST_COMPUTE:   if (r_cnt == r_len) w_state_nxt = ST_WAIT_SINK;
      ST_WAIT_SINK: if (sink_done_i || r_sink_seen) w_state_nxt = ST_FINISHED;
      ST_FINISHED:  w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
    if (clear_i) begin
      w_state_nxt = ST_IDLE;
      w_accept    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together on the edge, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt       <= '0;
      r_len       <= '0;
      r_pending   <= 1'b0;
      r_err       <= 1'b0;
      r_sink_seen <= 1'b0;
      r_clear     <= 1'b0;
    end else if (clear_i) begin
      r_cnt       <= '0;
      r_len       <= '0;
      r_pending   <= 1'b0;
      r_err       <= 1'b0;
      r_sink_seen <= 1'b0;
      r_clear     <= 1'b1;
    end else begin
      r_clear <= 1'b0;
      if (w_accept) begin
        r_len       <= len_i;
        r_cnt       <= '0;
        r_err       <= 1'b0;
        r_pending   <= 1'b0;
        r_sink_seen <= 1'b0;
      end else begin
        // A request arriving while the engine is not ready waits for it.
        if ((r_state == ST_IDLE) && start_i && !eng_ready_i) r_pending <= 1'b1;
        if (w_hs) begin
          if (r_cnt < r_len) r_cnt <= r_cnt + {{(LEN_W-1){1'b0}}, 1'b1};
          else               r_err <= 1'b1;
        end
        if (sink_done_i && ((r_state == ST_START) || (r_state == ST_COMPUTE)))
          r_sink_seen <= 1'b1;
      end
    end
  end

  assign eng_start_o  = (r_state == ST_START);
  assign src_start_o  = {2{r_state == ST_START}};
  assign sink_start_o = (r_state == ST_START);
  assign done_o       = (r_state == ST_FINISHED);
  assign eng_clear_o  = (r_state == ST_FINISHED) || r_clear;
  assign busy_o       = (r_state != ST_IDLE);
  assign cnt_o        = r_cnt;
  assign err_o        = r_err;

endmodule
